uart_sender: RTL and testbench
==============================

Name: uart_sender

Overview:
- Serial UART transmitter that sits on the far side of the Peripheral block's transmit interface.
- Peripheral presents a byte on UART_TXD and pulses TX_EN when TX_STATUS is high. This block serialises the byte onto the board TX pin as 8N1, LSB first.
- TX_STATUS tells Peripheral when the next byte may be issued.
- Pure transmitter; no FIFO. One byte in flight at a time.

Parameters:
- CLKS_PER_BIT, 10417, clk cycles per serial bit (100 MHz / 9600 baud); legal range 2..65535.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- UART_TXD  input  8  byte to send; driven by Peripheral.
- TX_EN  input  1  send request; sampled only while TX_STATUS=1.
- TX_STATUS  output  1  1 = idle and ready to accept, 0 = frame in progress.
- UART_TX  output  1  serial line; idle high.

Behaviour:
- Reset (reset=0, asynchronous):
  - UART_TX=1, TX_STATUS=1, state=IDLE.
  - Bit counter, baud counter and shift register = 0.
  - Reset asserted mid-frame aborts the frame; the line returns high immediately, without waiting for a clock edge.
- States: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
- IDLE:
  - UART_TX=1, TX_STATUS=1.
  - A rising edge with TX_EN=1 is the acceptance edge. On it: latch UART_TXD into the shift register, go to START, UART_TX<=0, TX_STATUS<=0, baud counter<=0.
- Baud counter:
  - Increments every cycle outside IDLE.
  - When it reaches CLKS_PER_BIT-1, it clears and the FSM advances one bit. Every bit is therefore exactly CLKS_PER_BIT cycles.
  - Counter width is clog2(CLKS_PER_BIT).
- START: after one bit time, go to DATA with UART_TX<=shift[0] and bit index 0.
- DATA:
  - Each bit time, shift right and drive the next LSB; bit index 0..7.
  - After bit 7's time, go to STOP with UART_TX<=1.
- STOP:
  - After one bit time, go to IDLE and set TX_STATUS<=1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles, measured from the acceptance edge to the edge where TX_STATUS rises.
- Changes to UART_TXD after the acceptance edge do not affect the frame in progress.
- TX_EN while TX_STATUS=0 is ignored and not queued. A byte offered while busy is lost; Peripheral must wait for TX_STATUS.
- Back-to-back sends (TX_EN held high):
  - The next frame is accepted on the first edge where TX_STATUS=1.
  - The line stays high for exactly one clk cycle between frames (stop bit plus one cycle).
- TX_EN and reset deasserting on the same edge: the request is not accepted, because the FSM leaves reset in IDLE and samples on the next edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: UART_SENDER_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives even parity (XOR of the latched byte) for one bit time.
  - Frame = 11*CLKS_PER_BIT cycles (8E1).
- Undefined:
  - No PARITY state or parity logic is synthesised.
  - Frame = 10*CLKS_PER_BIT cycles (8N1).

Test Plan:
- Reset check: bench uses CLKS_PER_BIT=16.
  - Hold reset=0 for 5 cycles -> UART_TX=1 and TX_STATUS=1 throughout.
  - Release reset; with TX_EN=0 for 50 cycles -> outputs unchanged.
- Single byte, bit pattern:
  - Stimulus: UART_TXD=0x55, TX_EN=1 for one cycle.
  - Sampling UART_TX at mid-bit (cycle 8 of each bit) gives 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop).
  - TX_STATUS is 0 for exactly 160 cycles.
- Busy and data stability:
  - Stimulus: send 0xA3, then pulse TX_EN with UART_TXD=0xFF at cycle 40, and keep UART_TXD changing while busy.
  - Required: the serial data is still 1,1,0,0,0,1,0,1, and no second frame follows.
- Back-to-back:
  - Stimulus: TX_EN held 1, UART_TXD=0x00 then 0xFF.
  - Required: two frames of 160 cycles each, with exactly 1 idle-high cycle between them; second frame data bits all 1.
- Reset mid-frame:
  - Stimulus: assert reset=0 at cycle 70 of a 0x00 frame.
  - Required: UART_TX=1 and TX_STATUS=1 within the same cycle; after release, a new 0x81 send produces a clean frame.
- Parity (with UART_SENDER_PARITY_EN defined):
  - Send 0x07 -> parity bit 1, frame 176 cycles.
  - Send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_sender.sv
// UART transmitter: serialises one byte per request as 8N1, LSB first.
// Define UART_SENDER_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_sender #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] UART_TXD,
  input  logic       TX_EN,
  output logic       TX_STATUS,
  output logic       UART_TX
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_SENDER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_reg, state_next;
  logic [CW-1:0]   baud_reg, baud_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic            tx_reg, tx_next;
  logic            status_reg, status_next;
  logic            baud_tick;
`ifdef UART_SENDER_PARITY_EN
  logic            parity_reg, parity_next;
`endif

  assign baud_tick = (baud_reg == BAUD_LAST);
  assign UART_TX   = tx_reg;
  assign TX_STATUS = status_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      status_reg  <= 1'b1;
`ifdef UART_SENDER_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      status_reg  <= status_next;
`ifdef UART_SENDER_PARITY_EN
      parity_reg  <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_tick ? '0 : baud_reg + 1'b1;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    status_next  = status_reg;
`ifdef UART_SENDER_PARITY_EN
    parity_next  = parity_reg;
`endif

    case (state_reg)
      IDLE: begin
        baud_next   = '0;
        tx_next     = 1'b1;
        status_next = 1'b1;
        if (TX_EN) begin
          shift_next  = UART_TXD;
          state_next  = START;
          tx_next     = 1'b0;
          status_next = 1'b0;
`ifdef UART_SENDER_PARITY_EN
          parity_next = ^UART_TXD;
`endif
        end
      end
      START: begin
        if (baud_tick) begin
          state_next   = DATA;
          tx_next      = shift_reg[0];
          bit_idx_next = 3'd0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_SENDER_PARITY_EN
            state_next = PARITY;
            tx_next    = parity_reg;
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            // shift_reg[1] becomes the new LSB after this shift
            shift_next   = {1'b0, shift_reg[7:1]};
            tx_next      = shift_reg[1];
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
`ifdef UART_SENDER_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          state_next  = IDLE;
          status_next = 1'b1;
          tx_next     = 1'b1;
        end
      end
      default: begin
        state_next  = IDLE;
        tx_next     = 1'b1;
        status_next = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_sender.sv
// Self-checking bench for uart_sender with a bit-level scoreboard.
// Define UART_SENDER_PARITY_EN on both files to exercise 8E1 frames.
module tb_uart_sender;

  localparam int CPB = 16;
`ifdef UART_SENDER_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] UART_TXD;
  logic       TX_EN;
  logic       TX_STATUS;
  logic       UART_TX;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  uart_sender #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .UART_TXD  (UART_TXD),
    .TX_EN     (TX_EN),
    .TX_STATUS (TX_STATUS),
    .UART_TX   (UART_TX)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push_frame(input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
`ifdef UART_SENDER_PARITY_EN
    exp_q.push_back(^b);
`endif
    exp_q.push_back(1'b1);
  endtask

  // One-cycle request; the following posedge is the acceptance edge.
  task automatic send(input logic [7:0] b, input bit push);
    @(posedge clk); #1;
    UART_TXD = b;
    TX_EN    = 1'b1;
    if (push) push_frame(b);
    @(posedge clk); #1;
    TX_EN = 1'b0;
  endtask

  // Records mid-bit line values and busy length of the next frame.
  task automatic capture_frame(output logic [10:0] bits, output int low,
                               output int idle, output logic end_tx,
                               output bit timeout);
    int k;
    bits = '1; low = 0; idle = 0; end_tx = 1'bx; timeout = 0;
    @(negedge clk);
    while (TX_STATUS !== 1'b0) begin
      idle++;
      if (idle > 40) begin timeout = 1; return; end
      @(negedge clk);
    end
    k = 0;
    while (TX_STATUS === 1'b0) begin
      if ((k % CPB) == CPB / 2 && (k / CPB) < 11) bits[k / CPB] = UART_TX;
      low++;
      k++;
      if (k > 20 * CPB) begin timeout = 1; return; end
      @(negedge clk);
    end
    end_tx = UART_TX;
  endtask

  task automatic test_reset();
    reset = 1'b0; TX_EN = 1'b0; UART_TXD = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (UART_TX !== 1'b1 || TX_STATUS !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold: tx=%b status=%b expected tx=1 status=1", UART_TX, TX_STATUS);
      end
    end
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (UART_TX !== 1'b1 || TX_STATUS !== 1'b1) begin
        errors++;
        $display("FAIL idle_after_reset: tx=%b status=%b expected tx=1 status=1", UART_TX, TX_STATUS);
      end
    end
    $display("reset: idle outputs checked for 55 cycles");
  endtask

  task automatic test_single(input logic [7:0] b, input string name);
    logic [10:0] bits; int low, idle; logic end_tx; bit to; logic e;
    send(b, 1);
    capture_frame(bits, low, idle, end_tx, to);
    checks++;
    if (to) begin errors++; $display("FAIL %s_timeout: frame not observed", name); end
    checks++;
    if (low != FB * CPB) begin
      errors++;
      $display("FAIL %s_length: busy %0d cycles, expected %0d", name, low, FB * CPB);
    end
    for (int i = 0; i < FB; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      checks++;
      if (bits[i] !== e) begin
        errors++;
        $display("FAIL %s_bit%0d: got %b expected %b", name, i, bits[i], e);
      end
    end
    checks++;
    if (end_tx !== 1'b1) begin
      errors++;
      $display("FAIL %s_line_idle: tx=%b after frame, expected 1", name, end_tx);
    end
    $display("%s: byte 0x%02h busy=%0d bits=%b", name, b, low, bits);
  endtask

  task automatic test_busy_ignored();
    logic [10:0] bits; int low, idle; logic end_tx; bit to; logic e; bit extra;
    send(8'hA3, 1);
    fork
      capture_frame(bits, low, idle, end_tx, to);
      begin
        repeat (39) @(posedge clk);
        #1 UART_TXD = 8'hFF; TX_EN = 1'b1;
        @(posedge clk); #1 TX_EN = 1'b0;
        for (int i = 0; i < 100; i++) begin
          @(posedge clk); #1 UART_TXD = 8'($urandom);
        end
      end
    join
    checks++;
    if (to || low != FB * CPB) begin
      errors++;
      $display("FAIL busy_length: busy %0d cycles (timeout=%0d), expected %0d", low, to, FB * CPB);
    end
    for (int i = 0; i < FB; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      checks++;
      if (bits[i] !== e) begin
        errors++;
        $display("FAIL busy_bit%0d: got %b expected %b", i, bits[i], e);
      end
    end
    extra = 0;
    for (int i = 0; i < 3 * FB * CPB; i++) begin
      @(negedge clk);
      if (TX_STATUS !== 1'b1 || UART_TX !== 1'b1) extra = 1;
    end
    checks++;
    if (extra) begin errors++; $display("FAIL busy_no_second_frame: activity seen=1 expected 0"); end
    $display("busy: byte 0xA3 busy=%0d bits=%b second_frame=%0d", low, bits, extra);
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits1, bits2; int low1, low2, idle1, idle2;
    logic end1, end2; bit to1, to2; logic e;
    @(posedge clk); #1;
    UART_TXD = 8'h00; TX_EN = 1'b1; push_frame(8'h00);
    @(posedge clk); #1;
    UART_TXD = 8'hFF; push_frame(8'hFF);
    fork
      begin
        capture_frame(bits1, low1, idle1, end1, to1);
        capture_frame(bits2, low2, idle2, end2, to2);
      end
      begin
        repeat (FB * CPB + 20) @(posedge clk);
        #1 TX_EN = 1'b0;
      end
    join
    checks++;
    if (to1 || to2 || low1 != FB * CPB || low2 != FB * CPB) begin
      errors++;
      $display("FAIL b2b_length: busy %0d/%0d (timeouts %0d/%0d), expected %0d each",
               low1, low2, to1, to2, FB * CPB);
    end
    checks++;
    if (end1 !== 1'b1 || idle2 != 0) begin
      errors++;
      $display("FAIL b2b_gap: gap tx=%b extra idle=%0d, expected tx=1 and exactly one idle cycle",
               end1, idle2);
    end
    for (int i = 0; i < 2 * FB; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      checks++;
      if (((i < FB) ? bits1[i] : bits2[i - FB]) !== e) begin
        errors++;
        $display("FAIL b2b_bit%0d: got %b expected %b", i,
                 (i < FB) ? bits1[i] : bits2[i - FB], e);
      end
    end
    $display("b2b: 0x00 bits=%b, 0xFF bits=%b, gap_idle=%0d", bits1, bits2, idle2 + 1);
  endtask

  task automatic test_reset_mid_frame();
    send(8'h00, 0);
    repeat (70) @(negedge clk);
    checks++;
    if (UART_TX !== 1'b0 || TX_STATUS !== 1'b0) begin
      errors++;
      $display("FAIL midreset_pre: tx=%b status=%b expected tx=0 status=0", UART_TX, TX_STATUS);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (UART_TX !== 1'b1 || TX_STATUS !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: tx=%b status=%b expected tx=1 status=1", UART_TX, TX_STATUS);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    $display("midreset: frame 0x00 aborted at cycle 70");
    test_single(8'h81, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single(8'h55, "single55");
    test_busy_ignored();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_SENDER_PARITY_EN
    test_single(8'h07, "parity07");
    test_single(8'h03, "parity03");
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
